pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL declare parameter NREG, default 32, meaning the number of architectural registers tracked.
REQ-002 SHALL declare parameter CNTW, default 16, meaning the stall performance counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port id_reg1_read, input, 1, the decode-stage read-port-1 enable.
REQ-006 SHALL have port id_reg1_addr, input, 5, the decode-stage read-port-1 address.
REQ-007 SHALL have port id_reg2_read, input, 1, the decode-stage read-port-2 enable.
REQ-008 SHALL have port id_reg2_addr, input, 5, the decode-stage read-port-2 address.
REQ-009 SHALL have port id_wreg, input, 1, meaning the decoded instruction writes a destination register.
REQ-010 SHALL have port id_wd, input, 5, the decoded destination register address.
REQ-011 SHALL have port id_long, input, 1, meaning the decoded instruction's result arrives only at writeback (load or multi-cycle).
REQ-012 SHALL have port ex_stallreq, input, 1, meaning the execute stage is busy with a multi-cycle operation.
REQ-013 SHALL have ports wb_wreg (input, 1) and wb_wd (input, 5), the writeback write enable and address.
REQ-014 SHALL have port stall, output, 6, the per-stage hold vector {wb,mem,ex,id,if,pc} (bit0 = pc).
REQ-015 SHALL have port busy, output, NREG, the per-register pending-write scoreboard.
REQ-016 SHALL have port stall_cnt, output, CNTW, the total number of stalled cycles.

Function
REQ-017 Issue SHALL be defined as stall[2]==0 in a cycle with id_wreg==1.
REQ-018 On issue with id_long==1 and id_wd!=0, busy[id_wd] SHALL be set at the next edge.
REQ-019 When wb_wreg==1, busy[wb_wd] SHALL be cleared at the next edge; a same-edge set to the same address SHALL take priority, leaving the bit set.
REQ-020 busy[0] SHALL always read 0.
REQ-021 hazard SHALL equal (id_reg1_read & busy[id_reg1_addr]) | (id_reg2_read & busy[id_reg2_addr]) | (id_wreg & busy[id_wd]), evaluated on effective busy.
REQ-022 Effective busy SHALL exclude a register being cleared by writeback in the same cycle (writeback bypass), so no stall is raised for that register.
REQ-023 The FSM SHALL have three states: RUN, HAZ, EXB.
REQ-024 FSM transitions SHALL be: ex_stallreq -> EXB; else hazard -> HAZ; else RUN. These are evaluated every cycle from any state, and ex_stallreq has priority.
REQ-025 stall SHALL be combinational from the next-state decode: EXB -> 6'b001111; HAZ -> 6'b000111; RUN -> 6'b000000. The registered state is for observation and counter attribution only.
REQ-026 When stall!=0, stall_cnt SHALL increment by 1 per cycle, saturating at all-ones.
REQ-027 Latency: busy SHALL update one cycle after issue or writeback; stall SHALL respond in the same cycle as its cause.
REQ-028 While stall[2]==1, no busy bit SHALL be set, even if id_long==1.

Reset
REQ-029 While rst==0: busy=0, stall_cnt=0, state=RUN, stall=6'b000000. This takes effect immediately, independent of clk, including during an in-progress stall.
REQ-030 After rst deasserts, the first edge SHALL behave as from an empty scoreboard.

Structure
REQ-031 The shared defines file SHALL hold the stall-vector constants (STALL_NONE, STALL_ID, STALL_EX), the FSM state encodings and the register-address width.
REQ-032 One sub-module, scoreboard (the NREG-bit set/clear array with bypass lookup), is natural; the FSM and counter SHALL stay in pipe_ctrl.

Verification
REQ-033 Issue id_wreg=1, id_long=1, id_wd=5; next cycle read reg1=5 -> stall=000111 held until wb_wreg=1, wb_wd=5, releasing to 000000 in that same cycle.
REQ-034 ex_stallreq=1 together with a reg2 hazard -> stall=001111; drop ex_stallreq with the hazard still pending -> stall=000111.
REQ-035 Same-edge set (id_wd=7) and clear (wb_wd=7) -> busy[7]=1 after the edge.
REQ-036 id_long issue to id_wd=0, then read r0 -> busy=0, stall=000000.
REQ-037 Force 2^CNTW+3 stall cycles -> stall_cnt=all-ones, no wrap to zero.
REQ-038 Assert rst=0 mid-HAZ between edges -> stall=0 and busy=0 immediately; after release, a read of the previously busy register -> no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW      = 5;
    localparam int unsigned STALL_W     = 6;
    localparam int unsigned HOLD_EX_BIT = 2;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HAZ = 2'd1,
        ST_EXB = 2'd2
    } state_e;

    // Stage hold vector implied by a controller state.
    function automatic logic [STALL_W-1:0] stall_of(input state_e s);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        case (s)
            ST_EXB:  v = STALL_EX;
            ST_HAZ:  v = STALL_ID;
            default: v = STALL_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute/writeback hazard inputs and stall/scoreboard outputs of pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 16
);
    import pipe_ctrl_pkg::*;

    logic                id_reg1_read;
    logic [REG_AW-1:0]   id_reg1_addr;
    logic                id_reg2_read;
    logic [REG_AW-1:0]   id_reg2_addr;
    logic                id_wreg;
    logic [REG_AW-1:0]   id_wd;
    logic                id_long;
    logic                ex_stallreq;
    logic                wb_wreg;
    logic [REG_AW-1:0]   wb_wd;

    logic [STALL_W-1:0]  stall;
    logic [NREG-1:0]     busy;
    logic [CNTW-1:0]     stall_cnt;
    state_e              state;

    modport master (
        output id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        output id_wreg, id_wd, id_long, ex_stallreq, wb_wreg, wb_wd,
        input  stall, busy, stall_cnt, state
    );

    modport slave (
        input  id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        input  id_wreg, id_wd, id_long, ex_stallreq, wb_wreg, wb_wd,
        output stall, busy, stall_cnt, state
    );

endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-write scoreboard: set on long-latency issue, clear on writeback, with
// same-cycle writeback bypass applied to the three hazard lookups.
module pipe_ctrl_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic [REG_AW-1:0] i_q1_addr,
    input  logic [REG_AW-1:0] i_q2_addr,
    input  logic [REG_AW-1:0] i_q3_addr,
    output logic [NREG-1:0]   o_busy,
    output logic [2:0]        o_hit_c
);

    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;
    logic [NREG-1:0] w_eff;

    // A register retiring this cycle no longer blocks anyone.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (i_set_en) w_set_vec = ONE << i_set_addr;
        if (i_clr_en) w_clr_vec = ONE << i_clr_addr;
        w_eff   = r_busy & ~w_clr_vec;
        o_hit_c = {w_eff[i_q3_addr], w_eff[i_q2_addr], w_eff[i_q1_addr]};
    end

    // Set wins over a same-edge clear; r0 never tracks a pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= ((r_busy & ~w_clr_vec) | w_set_vec) & ~ONE;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: RAW/WAW hazard detection against the scoreboard,
// execute-busy hold, per-stage stall vector and saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [STALL_W-1:0] w_stall;
    logic [CNTW-1:0]    r_stall_cnt;
    logic [NREG-1:0]    w_busy;
    logic [2:0]         w_hit;
    logic               w_hazard;
    logic               w_set_en;

    pipe_ctrl_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_set_en),
        .i_set_addr (bus.id_wd),
        .i_clr_en   (bus.wb_wreg),
        .i_clr_addr (bus.wb_wd),
        .i_q1_addr  (bus.id_reg1_addr),
        .i_q2_addr  (bus.id_reg2_addr),
        .i_q3_addr  (bus.id_wd),
        .o_busy     (w_busy),
        .o_hit_c    (w_hit)
    );

    assign w_hazard = (bus.id_reg1_read & w_hit[0])
                    | (bus.id_reg2_read & w_hit[1])
                    | (bus.id_wreg      & w_hit[2]);

    // Next-state decode; the stall vector follows the decoded state directly.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_stall     = STALL_NONE;
        if (bus.ex_stallreq)  w_state_nxt = ST_EXB;
        else if (w_hazard)    w_state_nxt = ST_HAZ;
        w_stall = stall_of(w_state_nxt);
    end

    // Only an instruction leaving decode may claim its destination.
    assign w_set_en = bus.id_wreg & ~w_stall[HOLD_EX_BIT] & bus.id_long
                    & (bus.id_wd != REG_AW'(0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          r_stall_cnt <= '0;
        else if ((w_stall != STALL_NONE) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end

    // Reset forces the hold vector off without waiting for an edge.
    assign bus.stall     = rst ? w_stall : STALL_NONE;
    assign bus.busy      = w_busy;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand sequences for
// reset/saturation, then randomized traffic against a register-level model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned NREG = 32;
    localparam int unsigned CNTW = 8;
    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SH = 6'b000111;
    localparam logic [5:0] SE = 6'b001111;
    localparam int NTBL = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.NREG(NREG), .CNTW(CNTW)) bus ();
    pipe_ctrl #(.NREG(NREG), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    bit mb [NREG];
    int m_cnt = 0;
    int cnt_max = (1 << CNTW) - 1;

    typedef struct {
        logic ex; logic r1; logic [4:0] a1; logic r2; logic [4:0] a2;
        logic wreg; logic [4:0] wd; logic lng; logic wbw; logic [4:0] wbd;
        logic [5:0] st; logic [31:0] bz;
    } vec_t;

    vec_t tbl [NTBL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int ex, r1, a1, r2, a2, wreg, wd, lng, wbw, wbd,
                                input logic [5:0] st, input logic [31:0] bz);
        vec_t v;
        v.ex = 1'(ex); v.r1 = 1'(r1); v.a1 = 5'(a1); v.r2 = 1'(r2); v.a2 = 5'(a2);
        v.wreg = 1'(wreg); v.wd = 5'(wd); v.lng = 1'(lng); v.wbw = 1'(wbw); v.wbd = 5'(wbd);
        v.st = st; v.bz = bz;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(input int a);
        logic [31:0] one;
        one = 32'd1;
        return one << a;
    endfunction

    task automatic drive(input vec_t v);
        bus.ex_stallreq  = v.ex;
        bus.id_reg1_read = v.r1;  bus.id_reg1_addr = v.a1;
        bus.id_reg2_read = v.r2;  bus.id_reg2_addr = v.a2;
        bus.id_wreg      = v.wreg; bus.id_wd       = v.wd;
        bus.id_long      = v.lng;
        bus.wb_wreg      = v.wbw; bus.wb_wd        = v.wbd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S0, 32'd0));
    endtask

    function automatic state_e st_of(input logic [5:0] s);
        if (s == SE) return ST_EXB;
        if (s == SH) return ST_HAZ;
        return ST_RUN;
    endfunction

    function automatic logic [NREG-1:0] model_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = mb[i];
        return v;
    endfunction

    // One cycle of the reference: a register blocks a reader/writer unless it is
    // retiring this cycle; busy execute outranks any register hazard.
    task automatic model_cycle(input vec_t v);
        bit haz;
        logic [5:0] exp_st;
        drive(v);
        haz = 1'b0;
        if (v.r1   && mb[v.a1] && !(v.wbw && v.wbd == v.a1)) haz = 1'b1;
        if (v.r2   && mb[v.a2] && !(v.wbw && v.wbd == v.a2)) haz = 1'b1;
        if (v.wreg && mb[v.wd] && !(v.wbw && v.wbd == v.wd)) haz = 1'b1;
        exp_st = v.ex ? SE : (haz ? SH : S0);
        #1;
        chk("rnd_stall", 64'(bus.stall), 64'(exp_st));
        @(posedge clk); #1;
        if (v.wbw) mb[v.wbd] = 1'b0;
        if (exp_st == S0 && v.wreg && v.lng && v.wd != 5'd0) mb[v.wd] = 1'b1;
        if (exp_st != S0 && m_cnt < cnt_max) m_cnt++;
        chk("rnd_busy",  64'(bus.busy),      64'(model_vec()));
        chk("rnd_cnt",   64'(bus.stall_cnt), 64'(m_cnt));
        chk("rnd_state", 64'(bus.state),     64'(st_of(exp_st)));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_stall", 64'(bus.stall), 64'(S0));
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_cnt",   64'(bus.stall_cnt), 64'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        for (int i = 0; i < NREG; i++) mb[i] = 1'b0;
        m_cnt = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t rv;
        idle();
        // Reset values, including stall gating while execute requests a hold.
        #1;
        chk("por_stall", 64'(bus.stall), 64'(S0));
        chk("por_busy",  64'(bus.busy),  64'd0);
        chk("por_cnt",   64'(bus.stall_cnt), 64'd0);
        chk("por_state", 64'(bus.state), 64'(ST_RUN));
        bus.ex_stallreq = 1'b1;
        #1;
        chk("por_ex_gated", 64'(bus.stall), 64'(S0));
        idle();
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        //              ex r1 a1 r2 a2 wr wd lg wbw wbd  stall busy-after
        tbl[0]  = mk(0, 0, 0, 0, 0, 1, 5, 1, 0, 0,  S0, bit_of(5));
        tbl[1]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  SH, bit_of(5));
        tbl[2]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  SH, bit_of(5));
        tbl[3]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 1, 5,  S0, 32'd0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 9, 1, 0, 0,  S0, bit_of(9));
        tbl[5]  = mk(1, 0, 0, 1, 9, 0, 0, 0, 0, 0,  SE, bit_of(9));
        tbl[6]  = mk(0, 0, 0, 1, 9, 0, 0, 0, 0, 0,  SH, bit_of(9));
        tbl[7]  = mk(0, 0, 0, 1, 9, 0, 0, 0, 1, 9,  S0, 32'd0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  S0, bit_of(7));
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 7, 1, 1, 7,  S0, bit_of(7));
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  S0, 32'd0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  S0, 32'd0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  S0, 32'd0);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0,  SE, 32'd0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 4, 0, 0, 0,  S0, 32'd0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 12, 1, 0, 0, S0, bit_of(12));
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 12, 1, 0, 0, SH, bit_of(12));
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, S0, 32'd0);

        for (int i = 0; i < NTBL; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_stall", i), 64'(bus.stall), 64'(tbl[i].st));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_busy", i),  64'(bus.busy),  64'(tbl[i].bz));
            chk($sformatf("tbl%0d_state", i), 64'(bus.state), 64'(st_of(tbl[i].st)));
        end
        chk("tbl_cnt", 64'(bus.stall_cnt), 64'd6);

        // Asynchronous reset in the middle of a register hazard.
        drive(mk(0, 0, 0, 0, 0, 1, 5, 1, 0, 0, S0, 32'd0));
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(bus.busy), 64'(bit_of(5)));
        drive(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, S0, 32'd0));
        #1;
        chk("pre_rst_stall", 64'(bus.stall), 64'(SH));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(bus.stall), 64'(S0));
        chk("mid_rst_busy",  64'(bus.busy),  64'd0);
        chk("mid_rst_cnt",   64'(bus.stall_cnt), 64'd0);
        chk("mid_rst_state", 64'(bus.state), 64'(ST_RUN));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("post_rst_stall", 64'(bus.stall), 64'(S0));
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_cnt",  64'(bus.stall_cnt), 64'd0);

        // Counter saturation under a long execute hold.
        bus.id_reg1_read = 1'b0;
        bus.ex_stallreq  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("cnt_10", 64'(bus.stall_cnt), 64'd10);
        repeat ((1 << CNTW) + 3 - 10) @(posedge clk);
        #1;
        chk("cnt_sat",       64'(bus.stall_cnt), 64'(cnt_max));
        chk("cnt_sat_stall", 64'(bus.stall), 64'(SE));
        idle();
        @(posedge clk); #1;
        chk("cnt_hold", 64'(bus.stall_cnt), 64'(cnt_max));

        do_reset();
        for (int n = 0; n < 400; n++) begin
            rv = mk(($urandom_range(0, 7) == 0) ? 1 : 0,
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    S0, 32'd0);
            model_cycle(rv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
